// File: rtl/rom_load_sequencer.sv
// rtl/rom_load_sequencer.sv - bridge-word FIFO feeding halfword writes into SDRAM during a ROM load
module rom_load_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int SD_ADDR_W  = 25
) (
  input  logic                 clk_mem,
  input  logic                 reset_n,
  input  logic [31:0]          rom_file_size,
  input  logic                 load_start,
  input  logic                 load_end,
  input  logic                 bridge_wr,
  input  logic [31:0]          bridge_addr,
  input  logic [31:0]          bridge_wr_data,
  output logic                 bridge_ready,
  output logic                 sd_req,
  output logic [SD_ADDR_W-1:0] sd_addr,
  output logic [15:0]          sd_data,
  input  logic                 sd_ack,
  output logic [24:0]          parse_addr,
  output logic [15:0]          parse_data,
  output logic                 parse_valid,
  output logic                 downloading,
  output logic                 done,
  output logic                 overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [PTR_W:0]     DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]     CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0]   PTR_ONE   = PTR_W'(1);
  localparam logic [SD_ADDR_W-1:0] SD_HDR  = SD_ADDR_W'(32'h200);

  logic [1:0]       state;
  logic [31:0]      fifo_addr [FIFO_DEPTH];
  logic [31:0]      fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             half_sel, has_hdr, ack_cool;
  logic [31:0]      size_q;

  logic             head_valid, in_range, hdr_zone, retire, advance, push, pop, drain_done;
  logic [31:0]      head_addr, head_data, hw_off;
  logic [15:0]      hw_val;
  logic [SD_ADDR_W-1:0] sd_off;

  // The FIFO head is the word being split; it is only popped once its second halfword is gone.
  always_comb begin
    head_valid = (count != '0);
    head_addr  = fifo_addr[rd_ptr];
    head_data  = fifo_data[rd_ptr];
    hw_off     = head_addr + {30'd0, half_sel, 1'b0};
    hw_val     = half_sel ? {head_data[7:0], head_data[15:8]}
                          : {head_data[23:16], head_data[31:24]};
    in_range   = (hw_off < size_q);
    hdr_zone   = has_hdr && (hw_off < 32'h200);
    sd_off     = hw_off[SD_ADDR_W-1:0] - (has_hdr ? SD_HDR : '0);
    sd_req     = head_valid && in_range && !hdr_zone && !ack_cool;
    sd_addr    = sd_req ? sd_off : '0;
    sd_data    = sd_req ? hw_val : '0;
    retire     = head_valid && in_range && (hdr_zone || (sd_req && sd_ack));
    advance    = head_valid && (!in_range || hdr_zone || (sd_req && sd_ack));
    pop        = advance && half_sel;
    bridge_ready = (state == ST_LOAD) && (count < DEPTH_CNT);
    push       = bridge_wr && bridge_ready;
    drain_done = (state == ST_DRAIN) && !head_valid;
    downloading = (state != ST_IDLE);
  end

  always_ff @(posedge clk_mem) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bridge_addr;
      fifo_data[wr_ptr] <= bridge_wr_data;
    end
  end

  always_ff @(posedge clk_mem) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      half_sel    <= 1'b0;
      has_hdr     <= 1'b0;
      size_q      <= '0;
      ack_cool    <= 1'b0;
      parse_addr  <= '0;
      parse_data  <= '0;
      parse_valid <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done        <= 1'b0;
      parse_valid <= retire;
      ack_cool    <= sd_req && sd_ack;
      if (retire) begin
        parse_addr <= hw_off[24:0];
        parse_data <= hw_val;
      end

      case (state)
        ST_IDLE: if (load_start) begin
          state    <= ST_LOAD;
          has_hdr  <= rom_file_size[9];
          size_q   <= rom_file_size;
          overflow <= 1'b0;
        end
        ST_LOAD: begin
          if (load_end) state <= ST_DRAIN;
          if (bridge_wr && !bridge_ready) overflow <= 1'b1;
        end
        ST_DRAIN: if (drain_done) begin
          state <= ST_IDLE;
          done  <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase

      if ((state == ST_IDLE) && load_start) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        half_sel <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop) rd_ptr <= rd_ptr + PTR_ONE;
        if (advance) half_sel <= !half_sel;
        case ({push, pop})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rom_load_sequencer.sv
// tb/tb_rom_load_sequencer.sv - randomized self-checking bench for rom_load_sequencer
module tb_rom_load_sequencer;
  localparam int FIFO_DEPTH = 4;
  localparam int SD_ADDR_W  = 25;

  logic clk_mem = 1'b0;
  always #5 clk_mem = ~clk_mem;

  logic        reset_n = 1'b0;
  logic [31:0] rom_file_size = '0;
  logic        load_start = 1'b0, load_end = 1'b0, bridge_wr = 1'b0;
  logic [31:0] bridge_addr = '0, bridge_wr_data = '0;
  logic        bridge_ready, sd_req, parse_valid, downloading, done, overflow;
  logic [SD_ADDR_W-1:0] sd_addr;
  logic [15:0] sd_data, parse_data;
  logic [24:0] parse_addr;
  logic        sd_ack = 1'b0;

  rom_load_sequencer #(.FIFO_DEPTH(FIFO_DEPTH), .SD_ADDR_W(SD_ADDR_W)) dut (
    .clk_mem(clk_mem), .reset_n(reset_n), .rom_file_size(rom_file_size),
    .load_start(load_start), .load_end(load_end), .bridge_wr(bridge_wr),
    .bridge_addr(bridge_addr), .bridge_wr_data(bridge_wr_data), .bridge_ready(bridge_ready),
    .sd_req(sd_req), .sd_addr(sd_addr), .sd_data(sd_data), .sd_ack(sd_ack),
    .parse_addr(parse_addr), .parse_data(parse_data), .parse_valid(parse_valid),
    .downloading(downloading), .done(done), .overflow(overflow)
  );

  int n_assert = 0, n_fail = 0;
  int cyc = 0, done_cnt = 0, viol = 0, last_parse_cyc = -1, done_cyc = -1;
  logic ack_en = 1'b0, ack_rand = 1'b0;
  int   ack_delay = 0, ack_wait = 0, cur_delay = 0;
  logic prev_req = 1'b0, prev_ack = 1'b0, prev_dl = 1'b0;
  logic [24:0] prev_addr = '0;
  logic [15:0] prev_data = '0;
  logic [40:0] got_wr[$], got_parse[$], exp_wr[$], exp_parse[$];
  logic [31:0] acc_a[$], acc_d[$];
  logic [31:0] wdat [0:8319];

  // SDRAM responder plus protocol monitor, sampled on the falling edge.
  always @(negedge clk_mem) begin
    cyc++;
    if (ack_en && sd_req) begin
      if (ack_wait >= cur_delay) begin
        sd_ack = 1'b1;
        ack_wait = 0;
        cur_delay = ack_rand ? int'($urandom_range(0, 3)) : ack_delay;
      end else begin
        sd_ack = 1'b0;
        ack_wait++;
      end
    end else begin
      sd_ack = 1'b0;
      if (!sd_req) ack_wait = 0;
    end
    if (reset_n) begin
      if (prev_req && !prev_ack && !(sd_req && sd_addr == prev_addr && sd_data == prev_data)) viol++;
      if (prev_req && prev_ack && sd_req) viol++;
      if (sd_req && sd_ack) got_wr.push_back({sd_addr, sd_data});
      if (parse_valid) begin
        got_parse.push_back({parse_addr, parse_data});
        last_parse_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (last_parse_cyc >= cyc) viol++;
      end
      if (prev_dl && !downloading && !done) viol++;
      prev_req = sd_req; prev_ack = sd_ack; prev_addr = sd_addr;
      prev_data = sd_data; prev_dl = downloading;
    end else begin
      prev_req = 1'b0; prev_ack = 1'b0; prev_dl = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk_mem);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ack(input logic en, input logic rnd, input int dly);
    ack_en = en; ack_rand = rnd; ack_delay = dly; cur_delay = dly;
  endtask

  task automatic start_load(input logic [31:0] sz);
    got_wr.delete(); got_parse.delete(); acc_a.delete(); acc_d.delete();
    rom_file_size = sz;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] a, input logic [31:0] d);
    int k = 0;
    if ($urandom_range(0, 3) == 0) tick();
    while (!bridge_ready && k < 500) begin
      tick();
      k++;
    end
    if (k >= 500) chk("push_timeout", 64'(k), 64'd0);
    bridge_wr = 1'b1; bridge_addr = a; bridge_wr_data = d;
    tick();
    bridge_wr = 1'b0;
    acc_a.push_back(a);
    acc_d.push_back(d);
  endtask

  task automatic stream(input int first, input int last);
    for (int i = first; i <= last; i++) push_word(32'(i * 4), wdat[i]);
  endtask

  // Expected SDRAM writes and parse events, straight from the halfword rules.
  task automatic build_model(input logic [31:0] sz);
    logic [31:0] off, sdo;
    logic [15:0] hw;
    logic        hdr;
    exp_wr.delete(); exp_parse.delete();
    hdr = sz[9];
    foreach (acc_a[i]) begin
      for (int h = 0; h < 2; h++) begin
        off = acc_a[i] + 32'(2 * h);
        hw  = (h == 0) ? {acc_d[i][23:16], acc_d[i][31:24]} : {acc_d[i][7:0], acc_d[i][15:8]};
        if (off < sz) begin
          exp_parse.push_back({off[24:0], hw});
          if (!(hdr && off < 32'h200)) begin
            sdo = off - (hdr ? 32'h200 : 32'h0);
            exp_wr.push_back({sdo[24:0], hw});
          end
        end
      end
    end
  endtask

  task automatic finish_load(input string tag, input logic [31:0] sz, input logic pulse_end);
    int d0, k, mism;
    d0 = done_cnt;
    if (pulse_end) begin
      load_end = 1'b1;
      tick();
      load_end = 1'b0;
    end
    k = 0;
    while (done_cnt == d0 && k < 5000) begin
      tick();
      k++;
    end
    repeat (4) tick();
    build_model(sz);
    chk({tag, "_done_once"}, 64'(done_cnt - d0), 64'd1);
    chk({tag, "_wr_count"}, 64'(got_wr.size()), 64'(exp_wr.size()));
    chk({tag, "_parse_count"}, 64'(got_parse.size()), 64'(exp_parse.size()));
    mism = 0;
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
      if (got_wr[i] !== exp_wr[i]) mism++;
    for (int i = 0; i < exp_parse.size() && i < got_parse.size(); i++)
      if (got_parse[i] !== exp_parse[i]) mism++;
    chk({tag, "_content_mismatches"}, 64'(mism), 64'd0);
    chk({tag, "_protocol_violations"}, 64'(viol), 64'd0);
    chk({tag, "_downloading_low"}, 64'(downloading), 64'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc, d0, k;
    logic [40:0] e;

    repeat (3) tick();
    chk("rst_sd_req", 64'(sd_req), 64'd0);
    chk("rst_downloading", 64'(downloading), 64'd0);
    chk("rst_done_parse_valid", 64'({done, parse_valid}), 64'd0);
    chk("rst_overflow_ready", 64'({overflow, bridge_ready}), 64'd0);
    chk("rst_sd_addr_data", 64'({sd_addr, sd_data}), 64'd0);
    chk("rst_parse_addr_data", 64'({parse_addr, parse_data}), 64'd0);
    reset_n = 1'b1;
    tick();

    // No header, 512 halfwords, ack one cycle after each request.
    set_ack(1'b1, 1'b0, 1);
    wdat[0] = 32'h11223344;
    for (int i = 1; i < 256; i++) wdat[i] = $urandom;
    start_load(32'h400);
    chk("load_downloading_high", 64'(downloading), 64'd1);
    stream(0, 255);
    finish_load("no_hdr", 32'h400, 1'b1);
    chk("no_hdr_512_writes", 64'(got_wr.size()), 64'd512);
    e = got_wr[0];
    chk("no_hdr_first_hw", 64'(e), 64'({25'h0, 16'h2211}));
    e = got_wr[1];
    chk("no_hdr_second_hw", 64'(e), 64'({25'h2, 16'h4433}));

    // Header present: first 0x200 bytes are parse-only.
    set_ack(1'b1, 1'b0, 0);
    for (int i = 0; i < 8320; i++) wdat[i] = $urandom;
    start_load(32'h8200);
    stream(0, 8319);
    finish_load("hdr", 32'h8200, 1'b1);
    chk("hdr_write_count", 64'(got_wr.size()), 64'd16384);
    chk("hdr_parse_count", 64'(got_parse.size()), 64'h4100);
    e = got_parse[0];
    chk("hdr_first_parse_addr", 64'(e[40:16]), 64'd0);
    e = got_wr[0];
    chk("hdr_first_write", 64'(e), 64'({25'h0, wdat[128][23:16], wdat[128][31:24]}));
    e = got_wr[$];
    chk("hdr_last_sd_addr", 64'(e[40:16]), 64'h7FFE);
    e = got_parse[$];
    chk("hdr_last_parse_addr", 64'(e[40:16]), 64'h81FE);

    // Size ends mid-word: only H0 of the last word is written.
    set_ack(1'b1, 1'b1, 0);
    for (int i = 0; i <= 256; i++) wdat[i] = $urandom;
    start_load(32'h402);
    stream(0, 256);
    finish_load("tail", 32'h402, 1'b1);
    chk("tail_write_count", 64'(got_wr.size()), 64'h201);
    e = got_wr[$];
    chk("tail_last_write", 64'(e), 64'({25'h400, wdat[256][23:16], wdat[256][31:24]}));

    // Backpressure: no acks while the bridge streams every cycle.
    set_ack(1'b0, 1'b0, 0);
    for (int i = 0; i < 16; i++) wdat[i] = $urandom;
    start_load(32'h40);
    n_acc = 0;
    for (int c = 0; c < 8; c++) begin
      if (bridge_ready) begin
        bridge_wr = 1'b1;
        bridge_addr = 32'(n_acc * 4);
        bridge_wr_data = wdat[n_acc];
        acc_a.push_back(bridge_addr);
        acc_d.push_back(bridge_wr_data);
        n_acc++;
      end else begin
        bridge_wr = 1'b0;
      end
      tick();
    end
    bridge_wr = 1'b0;
    chk("bp_words_accepted", 64'(n_acc), 64'(FIFO_DEPTH));
    chk("bp_ready_low", 64'(bridge_ready), 64'd0);
    chk("bp_no_overflow_yet", 64'(overflow), 64'd0);
    bridge_wr = 1'b1;
    bridge_addr = 32'(n_acc * 4);
    bridge_wr_data = wdat[n_acc];
    tick();
    bridge_wr = 1'b0;
    chk("bp_overflow_set", 64'(overflow), 64'd1);
    repeat (10) tick();
    chk("bp_req_held", 64'({sd_req, sd_addr, sd_data}),
        64'({1'b1, 25'h0, wdat[0][23:16], wdat[0][31:24]}));
    chk("bp_stable_during_hold", 64'(viol), 64'd0);
    set_ack(1'b1, 1'b1, 0);
    stream(n_acc, 15);
    finish_load("backpressure", 32'h40, 1'b1);
    chk("bp_overflow_sticky", 64'(overflow), 64'd1);

    // Reset while a request is outstanding.
    set_ack(1'b0, 1'b0, 0);
    start_load(32'h400);
    push_word(32'h0, $urandom);
    k = 0;
    while (!sd_req && k < 20) begin
      tick();
      k++;
    end
    chk("rst_mid_req_present", 64'(sd_req), 64'd1);
    d0 = done_cnt;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("rst_mid_req_cleared", 64'({sd_req, downloading, bridge_ready}), 64'd0);
    repeat (4) tick();
    chk("rst_mid_no_done", 64'(done_cnt - d0), 64'd0);
    set_ack(1'b1, 1'b1, 0);
    for (int i = 0; i < 8; i++) wdat[i] = $urandom;
    start_load(32'h20);
    chk("reload_downloading", 64'({downloading, overflow}), 64'({1'b1, 1'b0}));
    stream(0, 7);
    finish_load("after_reset", 32'h20, 1'b1);

    // load_end with three words still queued.
    set_ack(1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) wdat[i] = $urandom;
    start_load(32'd12);
    stream(0, 2);
    d0 = done_cnt;
    load_end = 1'b1;
    tick();
    load_end = 1'b0;
    bridge_wr = 1'b1; bridge_addr = 32'h0; bridge_wr_data = $urandom;
    tick();
    bridge_wr = 1'b0;
    repeat (4) tick();
    chk("drain_still_downloading", 64'(downloading), 64'd1);
    chk("drain_no_early_done", 64'(done_cnt - d0), 64'd0);
    chk("drain_wr_ignored_no_overflow", 64'(overflow), 64'd0);
    set_ack(1'b1, 1'b0, 1);
    finish_load("drain3", 32'd12, 1'b0);
    chk("drain_done_after_parse", 64'(done_cyc > last_parse_cyc), 64'd1);

    // Empty FIFO at load_end: DRAIN lasts one cycle.
    start_load(32'h0);
    tick();
    load_end = 1'b1;
    tick();
    load_end = 1'b0;
    chk("empty_drain_cycle", 64'({done, downloading}), 64'({1'b0, 1'b1}));
    tick();
    chk("empty_done_pulse", 64'({done, downloading}), 64'({1'b1, 1'b0}));
    tick();
    chk("empty_done_one_cycle", 64'(done), 64'd0);
    d0 = done_cnt;
    load_end = 1'b1;
    tick();
    load_end = 1'b0;
    repeat (3) tick();
    chk("idle_load_end_ignored", 64'({downloading, 6'(done_cnt - d0)}), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
